// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
// The pick policy is selected by SDRAM_ARB_FIXED_PRIO_EN (see sdram_arb_pick).
package sdram_arb_pkg;

  localparam int unsigned BEAT_W          = 5;
  localparam int unsigned DEF_BURST_LEN   = 32;
  localparam int unsigned DEF_ACK_TIMEOUT = 8191;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Port-index width for 2..4 requesters
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester-side bus of the SDRAM port arbiter: per-port request payload in,
// grant/beat qualifiers and shared read data out.
interface sdram_port_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 16
);

  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        rw;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS-1:0]        rvalid;
  logic [NUM_PORTS-1:0]        wready;
  logic [NUM_PORTS-1:0]        done;
  logic [DATA_W-1:0]           rdata;
  logic [BEAT_W-1:0]           beat;

  modport master (
    output req, rw, addr, wdata,
    input  gnt, rvalid, wready, done, rdata, beat
  );

  modport slave (
    input  req, rw, addr, wdata,
    output gnt, rvalid, wready, done, rdata, beat
  );

endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection: round-robin from i_ptr by default,
// lowest-index fixed priority when SDRAM_ARB_FIXED_PRIO_EN is defined.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 3,
  localparam int unsigned IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_ptr,
  output logic [NUM_PORTS-1:0] o_win_c,
  output logic [IDX_W-1:0]     o_idx_c,
  output logic                 o_any_c
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  assign o_any_c = |i_req;

  // Scan candidates in priority order; first requester wins
  always_comb begin
    o_win_c = '0;
    o_idx_c = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      w_cand = IDX_W'(off);
`else
      w_cand = IDX_W'((32'(i_ptr) + off) % NUM_PORTS);
`endif
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_win_c[w_cand] = 1'b1;
        o_idx_c         = w_cand;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM burst controller between NUM_PORTS requesters and routes beats.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest); default is round-robin.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 3,
  parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  sdram_port_arbiter_if.slave bus,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  input  logic                i_mem_bursting,
  output logic                o_err,
  output logic                o_mem_ce,
  output logic                o_mem_rw_req,
  output logic                o_mem_rw,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata
);

  localparam int unsigned IDX_W  = idx_w(NUM_PORTS);
  localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(BURST_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(ACK_TIMEOUT);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_PORTS - 1);

  arb_state_e           r_state, w_state_nxt;
  logic [NUM_PORTS-1:0] r_gnt, w_gnt_nxt;
  logic [NUM_PORTS-1:0] r_done, w_done_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [IDX_W-1:0]     r_rr, w_rr_nxt;
  logic [ADDR_W-1:0]    r_mem_addr, w_addr_nxt;
  logic                 r_mem_rw, w_rw_nxt;
  logic                 r_mem_ce, w_ce_nxt;
  logic                 r_mem_rw_req, w_rw_req_nxt;
  logic [BEAT_W-1:0]    r_beat, w_beat_nxt;
  logic [WAIT_W-1:0]    r_wait, w_wait_nxt;
  logic                 r_err, w_err_nxt;

  logic [NUM_PORTS-1:0] w_win;
  logic [IDX_W-1:0]     w_win_idx;
  logic                 w_any;
  logic                 w_beat_en;

  sdram_arb_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_rr),
    .o_win_c (w_win),
    .o_idx_c (w_win_idx),
    .o_any_c (w_any)
  );

  // A data beat is any controller bursting cycle while a grant is live
  assign w_beat_en = ((r_state == REQ) || (r_state == BURST)) && i_mem_bursting;

  assign bus.gnt    = r_gnt;
  assign bus.done   = r_done;
  assign bus.beat   = r_beat;
  assign bus.rdata  = i_mem_rdata;
  assign bus.rvalid = r_gnt & {NUM_PORTS{w_beat_en & ~r_mem_rw}};
  assign bus.wready = r_gnt & {NUM_PORTS{w_beat_en &  r_mem_rw}};

  assign o_err        = r_err;
  assign o_mem_ce     = r_mem_ce;
  assign o_mem_rw_req = r_mem_rw_req;
  assign o_mem_rw     = r_mem_rw;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = (|r_gnt) ? bus.wdata[32'(r_idx) * DATA_W +: DATA_W] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_gnt        <= '0;
      r_done       <= '0;
      r_idx        <= '0;
      r_rr         <= '0;
      r_mem_addr   <= '0;
      r_mem_rw     <= 1'b0;
      r_mem_ce     <= 1'b0;
      r_mem_rw_req <= 1'b0;
      r_beat       <= '0;
      r_wait       <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_done       <= w_done_nxt;
      r_idx        <= w_idx_nxt;
      r_rr         <= w_rr_nxt;
      r_mem_addr   <= w_addr_nxt;
      r_mem_rw     <= w_rw_nxt;
      r_mem_ce     <= w_ce_nxt;
      r_mem_rw_req <= w_rw_req_nxt;
      r_beat       <= w_beat_nxt;
      r_wait       <= w_wait_nxt;
      r_err        <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_done_nxt   = '0;
    w_idx_nxt    = r_idx;
    w_rr_nxt     = r_rr;
    w_addr_nxt   = r_mem_addr;
    w_rw_nxt     = r_mem_rw;
    w_ce_nxt     = r_mem_ce;
    w_rw_req_nxt = r_mem_rw_req;
    w_beat_nxt   = r_beat;
    w_wait_nxt   = r_wait;
    w_err_nxt    = r_err;

    if (w_beat_en && (r_beat != BEAT_MAX)) begin
      w_beat_nxt = r_beat + BEAT_W'(1);
    end

    case (r_state)
      IDLE: begin
        w_beat_nxt = '0;
        w_wait_nxt = '0;
        if (w_any) begin
          w_state_nxt  = REQ;
          w_gnt_nxt    = w_win;
          w_idx_nxt    = w_win_idx;
          w_addr_nxt   = bus.addr[32'(w_win_idx) * ADDR_W +: ADDR_W];
          w_rw_nxt     = bus.rw[w_win_idx];
          w_ce_nxt     = 1'b1;
          w_rw_req_nxt = 1'b1;
        end
      end
      REQ: begin
        if (i_mem_bursting) begin
          w_state_nxt  = BURST;
          w_rw_req_nxt = 1'b0;
        end else begin
          // Timeout only flags; the request stays up until the controller answers
          if (r_wait == WAIT_LAST) w_err_nxt = 1'b1;
          if (r_wait != WAIT_SAT)  w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      BURST: begin
        if (!i_mem_bursting) begin
          w_state_nxt = DONE;
          w_done_nxt  = r_gnt;
          w_gnt_nxt   = '0;
          w_ce_nxt    = 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
          w_rr_nxt    = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
`endif
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule
